// File: rtl/spi_arbiter_pkg.sv
// rtl/spi_arbiter_pkg.sv - shared constants for the two-port SPI bus arbiter
package spi_arbiter_pkg;

    localparam int N_REQ = 2;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_ACTIVE = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_GAP    = 3'd4;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin selector with a last-served register
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       take,
    output logic       sel
);

    logic last_q;
    logic last_d;

    always_comb begin
        case (req)
            2'b01:   sel = 1'b0;
            2'b10:   sel = 1'b1;
            default: sel = ~last_q;
        endcase
        last_d = last_q;
        if (take && (req != 2'b00)) begin
            last_d = sel;
        end
    end

    // last_q resets to 1 so requester 0 wins the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// rtl/spi_arbiter.sv - shares one SPI byte engine between two requesters
module spi_arbiter
    import spi_arbiter_pkg::*;
#(
    parameter int CS_SETUP = 2,
    parameter int CS_GAP   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    output logic [1:0]  gnt,
    input  logic [1:0]  tx_valid,
    input  logic [15:0] tx_data,
    output logic [1:0]  tx_ready,
    output logic [1:0]  rx_valid,
    output logic [7:0]  rx_data,
    input  logic [1:0]  rx_ready,
    output logic        spi_tx_valid,
    output logic [7:0]  spi_tx_data,
    input  logic        spi_tx_ready,
    input  logic        spi_rx_valid,
    input  logic [7:0]  spi_rx_data,
    output logic        spi_rx_ready,
    output logic        spi_ss,
    output logic        busy
);

    localparam logic [3:0] SETUP_LAST = (CS_SETUP == 0) ? 4'd0 : 4'(CS_SETUP - 1);
    localparam logic [3:0] GAP_LAST   = 4'(CS_GAP - 1);

    state_t     state_q, state_d;
    logic       owner_q, owner_d;
    logic [1:0] cnt_q, cnt_d;
    logic [3:0] timer_q, timer_d;
    logic       ss_q, ss_d;
    logic       sel;
    logic       take;
    logic       own_req;
    logic       tx_hs;
    logic       rx_hs;

    assign own_req = req[owner_q];
    assign spi_ss  = ss_q;
    assign busy    = (state_q != ST_IDLE);

    rr_arbiter2 u_rr (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .take  (take),
        .sel   (sel)
    );

    // Data-path steering; gnt follows req[owner] combinationally so it drops with req
    always_comb begin
        gnt          = 2'b00;
        tx_ready     = 2'b00;
        rx_valid     = 2'b00;
        spi_tx_valid = 1'b0;
        spi_rx_ready = 1'b1;
        spi_tx_data  = owner_q ? tx_data[15:8] : tx_data[7:0];
        rx_data      = spi_rx_data;
        if (state_q == ST_ACTIVE) begin
            gnt[owner_q]      = own_req;
            spi_tx_valid      = tx_valid[owner_q] & own_req;
            tx_ready[owner_q] = spi_tx_ready & own_req;
            rx_valid[owner_q] = spi_rx_valid;
            spi_rx_ready      = rx_ready[owner_q];
        end
    end

    always_comb begin
        tx_hs = spi_tx_valid & spi_tx_ready;
        rx_hs = spi_rx_valid & spi_rx_ready &
                ((state_q == ST_ACTIVE) || (state_q == ST_DRAIN));
        cnt_d = cnt_q;
        if (tx_hs && !rx_hs) begin
            cnt_d = cnt_q + 2'd1;
        end else if (rx_hs && !tx_hs && (cnt_q != 2'd0)) begin
            cnt_d = cnt_q - 2'd1;
        end

        state_d = state_q;
        owner_d = owner_q;
        timer_d = timer_q;
        ss_d    = ss_q;
        take    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    take    = 1'b1;
                    owner_d = sel;
                    state_d = ST_SETUP;
                    ss_d    = 1'b0;
                    timer_d = 4'd0;
                end
            end
            ST_SETUP: begin
                if (!own_req) begin
                    state_d = ST_GAP;
                    ss_d    = 1'b1;
                    timer_d = 4'd0;
                end else if (timer_q >= SETUP_LAST) begin
                    state_d = ST_ACTIVE;
                end else begin
                    timer_d = timer_q + 4'd1;
                end
            end
            ST_ACTIVE: begin
                if (!own_req) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == 2'd0) begin
                    state_d = ST_GAP;
                    ss_d    = 1'b1;
                    timer_d = 4'd0;
                end
            end
            ST_GAP: begin
                if (timer_q >= GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ss_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            cnt_q   <= 2'd0;
            timer_q <= 4'd0;
            ss_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            ss_q    <= ss_d;
        end
    end

endmodule
